bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Parametrised N-master bus arbiter; next generation of the 3-master fixed-priority arbiter.
- Adds:
  - generic master count;
  - run-time selectable fixed-priority or round-robin arbitration;
  - encoded grant index and busy flag;
  - a watchdog that force-releases a grant when the slave never acknowledges.
- Sits between bus masters' request lines and the shared-bus mux/slave ack path.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..16).
- IDX_W, $clog2(N_MASTERS), width of grant_idx (derived; do not override).
- TIMEOUT_CYCLES, 16, maximum grant tenure without bus_ack before forced release; 0 disables the watchdog.

Ports:
- clk  input  1  bus clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- bus_req  input  N_MASTERS  request vector, bit i = master i.
- bus_ack  input  1  slave acknowledges completion of the current tenure.
- rr_mode  input  1  0 = fixed priority (bit 0 highest), 1 = round-robin.
- bus_grant  output  N_MASTERS  registered one-hot grant, or all zero.
- grant_idx  output  IDX_W  index of the granted master; valid only when bus_busy=1.
- bus_busy  output  1  high while any grant is held.
- timeout_err  output  1  one-cycle pulse on a watchdog forced release.

Behaviour:
- Reset (async assert, sync release):
  - bus_grant=0, grant_idx=0, bus_busy=0, timeout_err=0;
  - state=IDLE, rr pointer=0, watchdog count=0.
- Invariants:
  - bus_grant is zero or one-hot;
  - bus_busy == (bus_grant != 0);
  - when busy, grant_idx equals the position of the set bit in bus_grant.
- Winner selection (combinational from bus_req, rr_mode, pointer):
  - fixed mode: lowest set index.
  - rr mode: first set index searching ptr, ptr+1, ..., N_MASTERS-1, 0, ..., ptr-1, with wrap-around.
- State IDLE:
  - bus_req==0: stay IDLE, grant stays 0.
  - otherwise: on the next edge, grant=onehot(winner), go BUSY. Latency from request to grant is 1 cycle.
- State BUSY:
  - The grant is held stable while bus_ack=0, even if the granted master drops its request.
  - bus_ack=1 and bus_req!=0: re-arbitrate on the same edge, new grant next cycle, stay BUSY. Back-to-back tenures have no idle cycle.
  - bus_ack=1 and bus_req==0: grant<=0, go IDLE.
  - In fixed mode, the same master may be re-granted immediately.
  - bus_ack is ignored in IDLE.
- RR pointer:
  - On every edge that loads a non-zero grant, ptr <= (winner+1) mod N_MASTERS.
  - Also updated on forced release (see watchdog), to skip the stalled master.
  - Not updated in fixed mode. A switch to rr_mode resumes from the last stored ptr.
- rr_mode changes take effect at the next arbitration decision; a held grant is never preempted.
- Watchdog (TIMEOUT_CYCLES>0):
  - count clears to 0 on every edge loading a new grant;
  - increments each BUSY cycle with bus_ack=0;
  - if count==TIMEOUT_CYCLES-1 and bus_ack=0:
    - grant<=0, go IDLE, timeout_err<=1 for exactly one cycle;
    - ptr <= (stalled idx+1) mod N_MASTERS (in rr mode).
  - The grant is therefore held at most TIMEOUT_CYCLES cycles.
  - bus_ack in the same cycle as expiry: ack wins, no error, normal re-arbitration.
  - After a forced release, IDLE arbitrates normally on the next edge.
- Reset mid-tenure: grant drops immediately (async); the pointer returns to 0.
- Width rules: pointer and count saturate within IDX_W and $clog2(TIMEOUT_CYCLES+1) bits; the pointer wraps modulo N_MASTERS, also when N_MASTERS is not a power of two.

Test Plan:
- N=4, fixed mode, IDLE, bus_req=4'b0110 -> next cycle bus_grant=4'b0010, grant_idx=1, bus_busy=1.
- rr_mode=1, bus_req=4'b1111 held, bus_ack=1 every BUSY cycle -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Granted 0100, bus_req dropped to 0, bus_ack=0 for 5 cycles then 1 -> grant stays 0100 for 5 cycles, then 0000, bus_busy=0.
- TIMEOUT_CYCLES=16, grant 0001, no ack -> grant held 16 cycles, then bus_grant=0 with a single-cycle timeout_err=1. With rr_mode=1 and bus_req=1111, the next grant is 0010.
- Ack asserted exactly in cycle 16 of the tenure -> no timeout_err, re-arbitration proceeds.
- Reset asserted asynchronously mid-tenure with grant=1000, rr ptr=3 -> outputs zero before the next edge; after release with bus_req=1111 in rr mode, the first grant is 0001.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter with run-time fixed-priority / round-robin selection,
// registered one-hot grant and a watchdog that reclaims grants from a silent slave.
//
// state | meaning
// IDLE  | no grant held; arbitrate on any request
// BUSY  | grant held until bus_ack or watchdog expiry
module bus_arbiter_rr #(
    parameter int N_MASTERS      = 4,
    parameter int IDX_W          = $clog2(N_MASTERS),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] bus_req,
    input  logic                 bus_ack,
    input  logic                 rr_mode,
    output logic [N_MASTERS-1:0] bus_grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 bus_busy,
    output logic                 timeout_err
);

    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tout_q, tout_d;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic                   load;
    int                     j;

    // Increment modulo N_MASTERS, correct for non-power-of-two counts.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (int'(v) >= N_MASTERS - 1) return '0;
        else return v + 1'b1;
    endfunction

    // Scan downward so the last hit is the first in search order.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        if (!rr_mode) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (bus_req[IDX_W'(i)]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int k = N_MASTERS - 1; k >= 0; k--) begin
                j = int'(ptr_q) + k;
                if (j >= N_MASTERS) j = j - N_MASTERS;
                if (bus_req[IDX_W'(j)]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(j);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) load = 1'b1;
            end
            BUSY: begin
                if (bus_ack) begin
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (WDOG_EN && cnt_q == CNT_TC) begin
                    // Ack never came: reclaim the bus and skip the stalled master.
                    state_d = IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tout_d  = 1'b1;
                    if (rr_mode) ptr_d = wrap_inc(idx_q);
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            state_d          = BUSY;
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            idx_d            = win_idx;
            cnt_d            = '0;
            if (rr_mode) ptr_d = wrap_inc(win_idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    assign bus_grant   = grant_q;
    assign grant_idx   = idx_q;
    assign bus_busy    = |grant_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (N=4, 16-cycle watchdog).
module tb_bus_arbiter_rr;

    logic       clk;
    logic       reset;
    logic [3:0] bus_req;
    logic       bus_ack;
    logic       rr_mode;
    logic [3:0] bus_grant;
    logic [1:0] grant_idx;
    logic       bus_busy;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    bus_arbiter_rr #(.N_MASTERS(4), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_req    (bus_req),
        .bus_ack    (bus_ack),
        .rr_mode    (rr_mode),
        .bus_grant  (bus_grant),
        .grant_idx  (grant_idx),
        .bus_busy   (bus_busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_req = 4'b0000; bus_ack = 1'b0; rr_mode = 1'b0;
        @(negedge clk);
        tests++; if (bus_grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want %b", bus_grant, 4'b0000); end
        tests++; if (grant_idx !== 2'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus_busy); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
        reset = 1'b0;
        tick();
        tests++; if (bus_grant !== 4'b0000) begin fails++; $display("FAIL idle_noreq: got %b want %b", bus_grant, 4'b0000); end
    endtask

    task automatic test_fixed();
        rr_mode = 1'b0; bus_req = 4'b0110; bus_ack = 1'b0;
        tick();
        tests++; if (bus_grant !== 4'b0010) begin fails++; $display("FAIL fixed_grant: got %b want %b", bus_grant, 4'b0010); end
        tests++; if (grant_idx !== 2'd1) begin fails++; $display("FAIL fixed_idx: got %0d want 1", grant_idx); end
        tests++; if (bus_busy !== 1'b1) begin fails++; $display("FAIL fixed_busy: got %b want 1", bus_busy); end
        bus_ack = 1'b1;
        tick();
        tests++; if (bus_grant !== 4'b0010) begin fails++; $display("FAIL fixed_regrant: got %b want %b", bus_grant, 4'b0010); end
        bus_req = 4'b0000;
        tick();
        tests++; if (bus_grant !== 4'b0000) begin fails++; $display("FAIL fixed_release: got %b want %b", bus_grant, 4'b0000); end
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL fixed_release_busy: got %b want 0", bus_busy); end
        tick();
        tests++; if (bus_grant !== 4'b0000) begin fails++; $display("FAIL idle_ack_ignored: got %b want %b", bus_grant, 4'b0000); end
        bus_ack = 1'b0;
    endtask

    task automatic test_rr_rotation();
        logic [3:0] seq [4];
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_mode = 1'b1; bus_req = 4'b1111; bus_ack = 1'b0;
        tick();
        tests++; if (bus_grant !== 4'b0001) begin fails++; $display("FAIL rr_first: got %b want %b", bus_grant, 4'b0001); end
        bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (bus_grant !== seq[i]) begin fails++; $display("FAIL rr_rot%0d: got %b want %b", i, bus_grant, seq[i]); end
            tests++; if (grant_idx !== 2'((i + 1) % 4)) begin fails++; $display("FAIL rr_rot_idx%0d: got %0d want %0d", i, grant_idx, (i + 1) % 4); end
        end
        bus_req = 4'b0000;
        tick();
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL rr_release: got %b want 0", bus_busy); end
        bus_ack = 1'b0;
    endtask

    // Pointer is 1 here.
    task automatic test_hold_no_ack();
        bus_req = 4'b0100; bus_ack = 1'b0;
        tick();
        tests++; if (bus_grant !== 4'b0100) begin fails++; $display("FAIL hold_load: got %b want %b", bus_grant, 4'b0100); end
        bus_req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (bus_grant !== 4'b0100) begin fails++; $display("FAIL hold_cyc%0d: got %b want %b", i, bus_grant, 4'b0100); end
        end
        bus_ack = 1'b1;
        tick();
        tests++; if (bus_grant !== 4'b0000) begin fails++; $display("FAIL hold_release: got %b want %b", bus_grant, 4'b0000); end
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL hold_release_busy: got %b want 0", bus_busy); end
        bus_ack = 1'b0;
    endtask

    // Pointer is 3 here: search order 3,0,1,2.
    task automatic test_rr_wrap();
        rr_mode = 1'b1; bus_req = 4'b0011; bus_ack = 1'b0;
        tick();
        tests++; if (bus_grant !== 4'b0001) begin fails++; $display("FAIL wrap_a: got %b want %b", bus_grant, 4'b0001); end
        bus_ack = 1'b1;
        tick();
        tests++; if (bus_grant !== 4'b0010) begin fails++; $display("FAIL wrap_b: got %b want %b", bus_grant, 4'b0010); end
        bus_req = 4'b0001;
        tick();
        tests++; if (bus_grant !== 4'b0001) begin fails++; $display("FAIL wrap_c: got %b want %b", bus_grant, 4'b0001); end
        bus_req = 4'b0000;
        tick();
        tests++; if (bus_grant !== 4'b0000) begin fails++; $display("FAIL wrap_release: got %b want %b", bus_grant, 4'b0000); end
        bus_ack = 1'b0;
    endtask

    // Pointer is 1 here; fixed mode must leave it alone.
    task automatic test_mode_switch();
        rr_mode = 1'b0; bus_req = 4'b0011; bus_ack = 1'b0;
        tick();
        tests++; if (bus_grant !== 4'b0001) begin fails++; $display("FAIL sw_fixed: got %b want %b", bus_grant, 4'b0001); end
        bus_ack = 1'b1; bus_req = 4'b0000;
        tick();
        bus_ack = 1'b0; rr_mode = 1'b1; bus_req = 4'b0011;
        tick();
        tests++; if (bus_grant !== 4'b0010) begin fails++; $display("FAIL sw_rr_resume: got %b want %b", bus_grant, 4'b0010); end
        bus_ack = 1'b1; bus_req = 4'b0000;
        tick();
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL sw_release: got %b want 0", bus_busy); end
        bus_ack = 1'b0;
    endtask

    // Pointer is 2 here.
    task automatic test_timeout();
        rr_mode = 1'b1; bus_req = 4'b0001; bus_ack = 1'b0;
        tick();
        tests++; if (bus_grant !== 4'b0001) begin fails++; $display("FAIL to_load: got %b want %b", bus_grant, 4'b0001); end
        bus_req = 4'b1111;
        for (int i = 2; i <= 16; i++) begin
            tick();
            tests++; if (bus_grant !== 4'b0001 || timeout_err !== 1'b0) begin
                fails++; $display("FAIL to_hold_cyc%0d: got grant %b terr %b want 0001 0", i, bus_grant, timeout_err);
            end
        end
        tick();
        tests++; if (bus_grant !== 4'b0000) begin fails++; $display("FAIL to_release: got %b want %b", bus_grant, 4'b0000); end
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b want 0", bus_busy); end
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_err: got %b want 1", timeout_err); end
        tick();
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_err_pulse: got %b want 0", timeout_err); end
        tests++; if (bus_grant !== 4'b0010) begin fails++; $display("FAIL to_next: got %b want %b", bus_grant, 4'b0010); end
        tests++; if (grant_idx !== 2'd1) begin fails++; $display("FAIL to_next_idx: got %0d want 1", grant_idx); end
    endtask

    // Entered in tenure cycle 1 of a 0010 grant, pointer 2, bus_req=1111.
    task automatic test_ack_at_expiry();
        for (int i = 2; i <= 16; i++) begin
            tick();
            tests++; if (bus_grant !== 4'b0010 || timeout_err !== 1'b0) begin
                fails++; $display("FAIL ae_hold_cyc%0d: got grant %b terr %b want 0010 0", i, bus_grant, timeout_err);
            end
        end
        bus_ack = 1'b1;
        tick();
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL ae_no_err: got %b want 0", timeout_err); end
        tests++; if (bus_grant !== 4'b0100) begin fails++; $display("FAIL ae_rearb: got %b want %b", bus_grant, 4'b0100); end
        tests++; if (bus_busy !== 1'b1) begin fails++; $display("FAIL ae_busy: got %b want 1", bus_busy); end
        bus_req = 4'b0000;
        tick();
        tests++; if (bus_grant !== 4'b0000) begin fails++; $display("FAIL ae_release: got %b want %b", bus_grant, 4'b0000); end
        bus_ack = 1'b0;
    endtask

    // Pointer is 3 here; fixed-mode grant keeps it at 3 before the reset.
    task automatic test_reset_mid();
        rr_mode = 1'b0; bus_req = 4'b1000; bus_ack = 1'b0;
        tick();
        tests++; if (bus_grant !== 4'b1000) begin fails++; $display("FAIL rm_load: got %b want %b", bus_grant, 4'b1000); end
        #2 reset = 1'b1;
        #1;
        tests++; if (bus_grant !== 4'b0000) begin fails++; $display("FAIL rm_async_grant: got %b want %b", bus_grant, 4'b0000); end
        tests++; if (bus_busy !== 1'b0) begin fails++; $display("FAIL rm_async_busy: got %b want 0", bus_busy); end
        tests++; if (grant_idx !== 2'd0) begin fails++; $display("FAIL rm_async_idx: got %0d want 0", grant_idx); end
        @(negedge clk);
        reset = 1'b0; rr_mode = 1'b1; bus_req = 4'b1111;
        tick();
        tests++; if (bus_grant !== 4'b0001) begin fails++; $display("FAIL rm_first_rr: got %b want %b", bus_grant, 4'b0001); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_rotation();
        test_hold_no_ack();
        test_rr_wrap();
        test_mode_switch();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
